vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_mod_counter.sv | 43 ++++
 rtl/vga_timing_gen.sv | 101 ++++++++++
 tb/tb_vga_timing_gen.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`timescale 1ns/1ps
// vga_pkg: shared 640x480@60 timing constants, counter widths and a window-decode helper.
package vga_pkg;

    localparam int CNT_W   = 10;
    localparam int FRAME_W = 16;

    // Horizontal timing, in pixel clocks
    localparam logic [CNT_W-1:0] H_VISIBLE    = 10'd640;
    localparam logic [CNT_W-1:0] H_FRONT      = 10'd16;
    localparam logic [CNT_W-1:0] H_SYNC       = 10'd96;
    localparam logic [CNT_W-1:0] H_BACK       = 10'd48;
    localparam logic [CNT_W-1:0] H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam logic [CNT_W-1:0] H_LAST       = H_TOTAL - 10'd1;
    localparam logic [CNT_W-1:0] H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam logic [CNT_W-1:0] H_SYNC_END   = H_SYNC_START + H_SYNC - 10'd1;

    // Vertical timing, in lines
    localparam logic [CNT_W-1:0] V_VISIBLE    = 10'd480;
    localparam logic [CNT_W-1:0] V_FRONT      = 10'd10;
    localparam logic [CNT_W-1:0] V_SYNC       = 10'd2;
    localparam logic [CNT_W-1:0] V_BACK       = 10'd33;
    localparam logic [CNT_W-1:0] V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [CNT_W-1:0] V_LAST       = V_TOTAL - 10'd1;
    localparam logic [CNT_W-1:0] V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam logic [CNT_W-1:0] V_SYNC_END   = V_SYNC_START + V_SYNC - 10'd1;

    // True when val lies in the inclusive range [lo, hi]
    function automatic logic in_window(input logic [CNT_W-1:0] val,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/vga_mod_counter.sv
`timescale 1ns/1ps
// vga_mod_counter: modulo (term_i + 1) counter with enable, next-value and wrap outputs.
// Any value above term_i (only reachable by an upset) returns to 0 on the next edge.
module vga_mod_counter
    import vga_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] term_i,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] count_d_o,
    output logic             wrap_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: recover from out-of-range first, otherwise advance when enabled
    always_comb begin
        count_d = count_q;
        if (count_q > term_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = (count_q == term_i) ? '0 : count_q + CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Wrap flag is valid in the cycle before the counter returns to 0 by wrapping
    assign wrap_o    = en_i && (count_q >= term_i);
    assign count_o   = count_q;
    assign count_d_o = count_d;

endmodule

// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// vga_timing_gen: 640x480@60 VGA timing generator with registered blank/sync/frame_start.
// Define VGA_FRAME_COUNT_EN to build the 16-bit completed-frame counter; otherwise frame_count is 0.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    output logic [CNT_W-1:0]   DrawX,
    output logic [CNT_W-1:0]   DrawY,
    output logic               blank,
    output logic               hs,
    output logic               vs,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count
);

    // Level driven onto hs/vs when the sync pulse is not active
    localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

    logic             run_q;
    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic             h_wrap, v_wrap;
    logic             blank_q, blank_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             fs_q, fs_d;

    // run_q holds the counters at (0,0) for the first edge after reset release
    vga_mod_counter u_hcnt (
        .clk_i     (vga_clk),
        .reset_n_i (reset_n),
        .en_i      (run_q),
        .term_i    (H_LAST),
        .count_o   (h_q),
        .count_d_o (h_d),
        .wrap_o    (h_wrap)
    );

    vga_mod_counter u_vcnt (
        .clk_i     (vga_clk),
        .reset_n_i (reset_n),
        .en_i      (h_wrap),
        .term_i    (V_LAST),
        .count_o   (v_q),
        .count_d_o (v_d),
        .wrap_o    (v_wrap)
    );

    // Decode outputs from the counter values about to be loaded, so they line up with DrawX/DrawY
    always_comb begin
        blank_d = (h_d < H_VISIBLE) && (v_d < V_VISIBLE);
        hs_d    = in_window(h_d, H_SYNC_START, H_SYNC_END) ^ SYNC_IDLE;
        vs_d    = in_window(v_d, V_SYNC_START, V_SYNC_END) ^ SYNC_IDLE;
        fs_d    = v_wrap || !run_q;
    end

    // Registered timing outputs and the post-reset start flag
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q   <= 1'b0;
            blank_q <= 1'b0;
            hs_q    <= SYNC_IDLE;
            vs_q    <= SYNC_IDLE;
            fs_q    <= 1'b0;
        end else begin
            run_q   <= 1'b1;
            blank_q <= blank_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            fs_q    <= fs_d;
        end
    end

    assign DrawX       = h_q;
    assign DrawY       = v_q;
    assign blank       = blank_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign frame_start = fs_q;

`ifdef VGA_FRAME_COUNT_EN
    logic [FRAME_W-1:0] frame_cnt_q;

    // Count each vertical wrap; a reset discards any partial frame
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= '0;
        end else if (v_wrap) begin
            frame_cnt_q <= frame_cnt_q + FRAME_W'(1);
        end
    end

    assign frame_count = frame_cnt_q;
`else
    assign frame_count = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// tb_vga_timing_gen: directed, scoreboard-based bench for vga_timing_gen (SYNC_ACTIVE_LOW = 1).
// Far-away counter positions are reached by briefly forcing the counter registers.
module tb_vga_timing_gen;

    logic        vga_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  DrawX, DrawY;
    logic        blank, hs, vs, frame_start;
    logic [15:0] frame_count;

    vga_timing_gen #(.SYNC_ACTIVE_LOW(1)) dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .hs          (hs),
        .vs          (vs),
        .frame_start (frame_start),
        .frame_count (frame_count)
    );

    always #20 vga_clk = ~vga_clk;

    typedef struct {
        int   x;
        int   y;
        logic blank;
        logic hs;
        logic vs;
        logic fs;
        int   fc;
    } exp_t;

    exp_t sb[$];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   mx = 0, my = 0, mfc = 0;
    bit   m_started = 0;
    int   hs_low_cnt = 0, vs_low_cnt = 0, fs_cnt = 0;
    logic [9:0] jx, jy;
`ifdef VGA_FRAME_COUNT_EN
    localparam bit FC_EN = 1'b1;
`else
    localparam bit FC_EN = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (x=%0d y=%0d)", tag, obs, expv, mx, my);
        end
    endtask

    // Reference model: advance one pixel clock and queue the outputs it should produce
    task automatic model_push();
        exp_t e;
        int   nx, ny;
        bit   hwrap;
        if (!m_started) begin
            nx = 0; ny = 0;
        end else begin
            hwrap = (mx >= 799);
            nx    = hwrap ? 0 : mx + 1;
            if (my > 524) ny = 0;
            else if (hwrap) begin
                if (my == 524) begin
                    ny  = 0;
                    mfc = (mfc + 1) % 65536;
                end else ny = my + 1;
            end else ny = my;
        end
        m_started = 1;
        mx = nx; my = ny;
        e.x     = nx;
        e.y     = ny;
        e.blank = (nx < 640) && (ny < 480);
        e.hs    = !((nx >= 656) && (nx <= 751));
        e.vs    = !((ny >= 490) && (ny <= 491));
        e.fs    = (nx == 0) && (ny == 0);
        e.fc    = FC_EN ? mfc : 0;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty: observed 0 entries expected 1");
            return;
        end
        n_tests--;
        e = sb.pop_front();
        chk("DrawX", 32'(DrawX), 32'(e.x));
        chk("DrawY", 32'(DrawY), 32'(e.y));
        chk("blank", 32'(blank), 32'(e.blank));
        chk("hs", 32'(hs), 32'(e.hs));
        chk("vs", 32'(vs), 32'(e.vs));
        chk("frame_start", 32'(frame_start), 32'(e.fs));
        chk("frame_count", 32'(frame_count), 32'(e.fc));
        if (hs === 1'b0) hs_low_cnt++;
        if (vs === 1'b0) vs_low_cnt++;
        if (frame_start === 1'b1) fs_cnt++;
    endtask

    task automatic step();
        model_push();
        @(posedge vga_clk);
        #1;
        pop_check();
    endtask

    task automatic run_to(input int tx, input int ty);
        int guard = 0;
        while (!(mx == tx && my == ty) && guard < 20000) begin
            step();
            guard++;
        end
        chk("run_to_bound", 32'(guard < 20000), 32'd1);
    endtask

    // Jump both counters to (x,y) between clock edges; the model follows
    task automatic jump(input int x, input int y);
        @(negedge vga_clk);
        jx = 10'(x);
        jy = 10'(y);
        force dut.u_hcnt.count_q = jx;
        force dut.u_vcnt.count_q = jy;
        #1;
        release dut.u_hcnt.count_q;
        release dut.u_vcnt.count_q;
        mx = x; my = y;
        $display("[TB] jump to (%0d,%0d)", x, y);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_DrawX"}, 32'(DrawX), 32'd0);
        chk({tag, "_DrawY"}, 32'(DrawY), 32'd0);
        chk({tag, "_blank"}, 32'(blank), 32'd0);
        chk({tag, "_hs"}, 32'(hs), 32'd1);
        chk({tag, "_vs"}, 32'(vs), 32'd1);
        chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        chk({tag, "_frame_count"}, 32'(frame_count), 32'd0);
        $display("[TB] %s reset-state check done", tag);
    endtask

    task automatic release_reset();
        @(negedge vga_clk);
        reset_n   = 1'b1;
        mx = 0; my = 0; mfc = 0;
        m_started = 0;
    endtask

    initial begin
        // Power-on reset
        repeat (3) @(posedge vga_clk);
        #1;
        check_reset_state("por");

        // Reset release: (0,0) with frame_start, then DrawX=1 without it
        release_reset();
        step();
        chk("rel0_blank", 32'(blank), 32'd1);
        chk("rel0_fs", 32'(frame_start), 32'd1);
        step();
        chk("rel1_DrawX", 32'(DrawX), 32'd1);
        chk("rel1_fs", 32'(frame_start), 32'd0);
        $display("[TB] reset release checked");

        // One full line of hsync
        run_to(799, 1);
        hs_low_cnt = 0;
        repeat (800) step();
        chk("hs_low_per_line", 32'(hs_low_cnt), 32'd96);
        $display("[TB] hs window: %0d low cycles on line 2", hs_low_cnt);

        // Line wrap at DrawY=5
        run_to(799, 5);
        step();
        chk("linewrap_DrawX", 32'(DrawX), 32'd0);
        chk("linewrap_DrawY", 32'(DrawY), 32'd6);
        $display("[TB] line wrap (799,5)->(%0d,%0d)", DrawX, DrawY);

        // Blank edges at the right and bottom of the visible area
        jump(630, 479);
        run_to(639, 479);
        chk("blank_639_479", 32'(blank), 32'd1);
        step();
        chk("blank_640_479", 32'(blank), 32'd0);
        jump(790, 479);
        run_to(0, 480);
        chk("blank_0_480", 32'(blank), 32'd0);
        $display("[TB] blank edges checked");

        // Vertical sync over lines 488..493
        jump(799, 487);
        vs_low_cnt = 0;
        repeat (4800) step();
        chk("vs_low_per_frame", 32'(vs_low_cnt), 32'd1600);
        $display("[TB] vs window: %0d low cycles", vs_low_cnt);

        // Three frame wraps
        fs_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            jump(796, 524);
            repeat (4) step();
            chk("wrap_blank_0_0", 32'(blank), 32'd1);
            chk("wrap_fs", 32'(frame_start), 32'd1);
            $display("[TB] frame wrap %0d, frame_count=%0d", i + 1, frame_count);
        end
        chk("fs_pulses", 32'(fs_cnt), 32'd3);
        chk("frame_count_3", 32'(frame_count), FC_EN ? 32'd3 : 32'd0);

        // Out-of-range counter values recover to 0
        jump(900, 10);
        step();
        chk("oor_h_DrawX", 32'(DrawX), 32'd0);
        chk("oor_h_DrawY", 32'(DrawY), 32'd11);
        jump(100, 600);
        step();
        chk("oor_v_DrawX", 32'(DrawX), 32'd101);
        chk("oor_v_DrawY", 32'(DrawY), 32'd0);
        $display("[TB] out-of-range recovery checked");

        // Mid-frame reset at (300,200)
        jump(299, 200);
        step();
        chk("mid_DrawX", 32'(DrawX), 32'd300);
        reset_n = 1'b0;
        #1;
        check_reset_state("mid");
        repeat (2) @(posedge vga_clk);
        release_reset();
        step();
        chk("mid_rel_fs", 32'(frame_start), 32'd1);
        chk("mid_rel_fc", 32'(frame_count), 32'd0);
        step();
        chk("mid_rel_DrawX", 32'(DrawX), 32'd1);
        $display("[TB] mid-frame reset restart checked");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time bound so the bench always terminates
    initial begin
        #5ms;
        $display("FAIL timeout: observed no finish expected finish within 5ms");
        $fatal(1, "timeout");
    end

endmodule
